// File: rtl/uart_tx.sv
// uart_tx: serial transmitter sending start, LSB-first data, optional parity and stop bits, one bit per tick
// ports: clk clock; reset async active-low; tick one pulse per bit period; tx_start/tx_data send request;
//        tx serial line (idle high); tx_busy frame in progress; tx_done one-clk pulse at frame end
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n, rot;
  logic [BW-1:0] bit_cnt, bit_n;
  logic stop_cnt, stop_n, tx_n, busy_n, done_n, parity;
  // rotating rather than shifting leaves the latched word intact once all data bits are out
  assign rot = {shift[0], shift[DATA_BITS-1:1]};
  assign parity = ^shift ^ (PARITY_ODD != 0);
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n = bit_cnt;
    stop_n = stop_cnt;
    tx_n = tx;
    busy_n = tx_busy;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        busy_n = tx_start;
        if (tx_start) begin
          shift_n = tx_data;
          state_n = SYNC;
        end
      end
      SYNC: if (tick) begin
        state_n = START;
        tx_n = 1'b0;
      end
      START: if (tick) begin
        state_n = DATA;
        tx_n = shift[0];
        shift_n = rot;
        bit_n = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt == BW'(DATA_BITS - 1)) begin
          state_n = (PARITY_EN != 0) ? PARITY : STOP;
          tx_n = (PARITY_EN != 0) ? parity : 1'b1;
          stop_n = 1'b0;
        end else begin
          tx_n = shift[0];
          shift_n = rot;
          bit_n = bit_cnt + 1'b1;
        end
      end
      PARITY: if (tick) begin
        state_n = STOP;
        tx_n = 1'b1;
        stop_n = 1'b0;
      end
      STOP: if (tick) begin
        if (stop_cnt == 1'(STOP_BITS - 1)) begin
          state_n = IDLE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end else stop_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
        tx_n = 1'b1;
        busy_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_n;
      stop_cnt <= stop_n;
      tx <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks three uart_tx configurations cycle by cycle against a tick-counting frame model
module tb_uart_tx;
  localparam int DB [3] = '{8, 8, 7};
  localparam int PE [3] = '{0, 1, 1};
  localparam int PO [3] = '{0, 0, 1};
  localparam int SB [3] = '{1, 2, 1};
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic [2:0] st = '0, txl, bsy, dn;
  logic [7:0] data = '0;
  int checks = 0, passes = 0, fails = 0, tick_per = 4, phase = 1;
  always #5 clk = ~clk;
  uart_tx #(.DATA_BITS(DB[0]), .PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(SB[0])) u0 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(st[0]), .tx_data(data),
    .tx(txl[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  uart_tx #(.DATA_BITS(DB[1]), .PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(SB[1])) u1 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(st[1]), .tx_data(data),
    .tx(txl[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  uart_tx #(.DATA_BITS(DB[2]), .PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(SB[2])) u2 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(st[2]), .tx_data(data[6:0]),
    .tx(txl[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
  function automatic logic [2:0] obs(input int k);
    return {txl[k], bsy[k], dn[k]};
  endfunction
  // bit j of the serial frame for instance k: start, data LSB first, optional parity, stop bits
  function automatic logic fbit(input int k, input int d, input int j);
    logic p;
    p = PO[k] != 0;
    for (int i = 0; i < DB[k]; i++) p ^= d[i];
    if (j == 0) return 1'b0;
    if (j <= DB[k]) return d[j-1];
    if (PE[k] != 0 && j == DB[k] + 1) return p;
    return 1'b1;
  endfunction
  task automatic chk(input string tag, input int k, input logic [2:0] o, input logic [2:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s u%0d: {tx,busy,done} got %b want %b", tag, k, o, e);
    end
  endtask
  task automatic step(output logic t);
    t = (tick_per <= 1) || (phase % tick_per == 0);
    tick = t;
    phase++;
    @(posedge clk);
    #1;
  endtask
  // sends d on instance k; optional stray tx_start at cycle mid_at, optional reset once abort_n ticks are seen
  task automatic frame(input string tag, input int k, input int d, input int mid_at, input int abort_n);
    int n, c, nb;
    logic t;
    nb = 1 + DB[k] + PE[k] + SB[k];
    st[k] = 1'b1;
    data = 8'(d);
    step(t);
    chk({tag, "_accept"}, k, obs(k), 3'b110);
    n = 0;
    c = 0;
    while (n <= nb) begin
      st[k] = (c == mid_at);
      data = st[k] ? 8'hFF : 8'($urandom);
      step(t);
      c++;
      if (t) n++;
      if (abort_n >= 0 && n == abort_n) begin
        st[k] = 1'b0;
        reset = 1'b0;
        #1;
        chk({tag, "_async_rst"}, k, obs(k), 3'b100);
        repeat (2) begin
          step(t);
          chk({tag, "_in_rst"}, k, obs(k), 3'b100);
        end
        reset = 1'b1;
        step(t);
        chk({tag, "_post_rst"}, k, obs(k), 3'b100);
        return;
      end
      chk(tag, k, obs(k), (n > nb) ? 3'b101 : {(n == 0) ? 1'b1 : fbit(k, d, n - 1), 2'b10});
    end
    st[k] = 1'b0;
  endtask
  initial begin
    logic t;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("reset", k, obs(k), 3'b100);
    reset = 1'b1;
    step(t);
    for (int k = 0; k < 3; k++) chk("idle", k, obs(k), 3'b100);
    frame("a5", 0, 'hA5, -1, -1);
    frame("par_even", 1, 'h07, -1, -1);
    frame("par_odd", 2, 'h07, -1, -1);
    tick_per = 10;
    phase = 0;
    frame("coincident", 0, 'h96, -1, -1);
    tick_per = 4;
    frame("stray_start", 0, 'h12, 15, -1);
    frame("b2b", 0, 'h3C, -1, -1);
    frame("abort", 0, 'hC3, -1, 5);
    frame("after_rst", 0, 'h81, -1, -1);
    tick_per = 1;
    frame("tick_high", 0, 'h5A, -1, -1);
    for (int i = 0; i < 8; i++) begin
      tick_per = $urandom_range(1, 6);
      frame("rand", $urandom_range(0, 2), $urandom, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 25) : -1, -1);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
